// File: rtl/ctrl_pkg.sv
// Shared types and default sizing for the run controller and its helpers.
package ctrl_pkg;

    // Sequencer states for one harness-driven run of the core.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ARM   = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    // Default watchdog limit in RUN cycles and the counter width that covers it.
    localparam int DEF_TIMEOUT = 4096;
    localparam int DEF_CW      = 16;

endpackage

// File: rtl/addr_walker.sv
// Clearable up-counter that walks the data-memory address space during a clear.
// last flags the final word so the sequencer can leave CLEAR on that cycle.
module addr_walker
    import ctrl_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [AW-1:0] addr_r;

    // Address register: clear has priority over increment so an exit from
    // CLEAR always leaves the walker at word 0 for the next request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_r <= {AW{1'b0}};
        end else if (clr) begin
            addr_r <= {AW{1'b0}};
        end else if (en) begin
            addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr = addr_r;
    assign last = (addr_r == {AW{1'b1}});

endmodule

// File: rtl/run_controller.sv
// Run sequencer for the 8-bit core: clears data memory, releases the core
// from reset, times the run with a watchdog and reports done/timeout.
module run_controller
    import ctrl_pkg::*;
#(
    parameter int          AW      = 8,
    parameter int          DW      = 8,
    parameter logic [DW-1:0] CLR_VAL = {DW{1'b0}},
    parameter int          CLR_EN  = 1,
    parameter int          TIMEOUT = DEF_TIMEOUT,
    parameter int          CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    output logic          core_rst,
    output logic          mem_sel,
    output logic          init_wr_en,
    output logic [AW-1:0] init_addr,
    output logic [DW-1:0] init_dat,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TIMEOUT_VAL  = CW'(TIMEOUT);

    run_state_t    state_r;
    run_state_t    next_state_s;
    logic          req_q_r;
    logic [CW-1:0] cycles_r;
    logic          timeout_r;
    logic          done_r;
    logic          core_rst_r;
    logic          mem_sel_r;
    logic          init_wr_en_r;
    logic          walker_clr_s;
    logic          walker_en_s;
    logic [AW-1:0] walker_addr_s;
    logic          walker_last_s;

    // The walker is held at 0 on every edge that does not stay in CLEAR.
    assign walker_clr_s = (next_state_s != CLEAR);
    assign walker_en_s  = (state_r == CLEAR);

    addr_walker #(
        .AW (AW)
    ) u_addr_walker (
        .clk   (clk),
        .reset (reset),
        .clr   (walker_clr_s),
        .en    (walker_en_s),
        .addr  (walker_addr_s),
        .last  (walker_last_s)
    );

    // Start request is registered once; a run begins the edge after it is seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q_r <= 1'b0;
        end else begin
            req_q_r <= req;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a dropped req aborts CLEAR/ARM/RUN, core_done beats the watchdog.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_q_r) begin
                    if (CLR_EN != 0) begin
                        next_state_s = CLEAR;
                    end else begin
                        next_state_s = ARM;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            CLEAR: begin
                if (!req) begin
                    next_state_s = IDLE;
                end else if (walker_last_s) begin
                    next_state_s = ARM;
                end else begin
                    next_state_s = CLEAR;
                end
            end
            ARM: begin
                if (!req) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            RUN: begin
                if (!req) begin
                    next_state_s = IDLE;
                end else if (core_done) begin
                    next_state_s = DONE;
                end else if (cycles_r == TIMEOUT_LAST) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (!req) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Cycle counter and timeout flag: zeroed on ARM->RUN, saturate at TIMEOUT on the watchdog.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycles_r  <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else if ((state_r == ARM) && (next_state_s == RUN)) begin
            cycles_r  <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else if ((state_r == RUN) && (next_state_s == DONE) && !core_done) begin
            cycles_r  <= TIMEOUT_VAL;
            timeout_r <= 1'b1;
        end else if ((state_r == RUN) && (next_state_s == RUN)) begin
            cycles_r  <= cycles_r + {{(CW-1){1'b0}}, 1'b1};
            timeout_r <= timeout_r;
        end else begin
            cycles_r  <= cycles_r;
            timeout_r <= timeout_r;
        end
    end

    // Output registers loaded from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_rst_r   <= 1'b1;
            mem_sel_r    <= 1'b0;
            init_wr_en_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            core_rst_r   <= (next_state_s != RUN);
            mem_sel_r    <= (next_state_s == CLEAR);
            init_wr_en_r <= (next_state_s == CLEAR);
            done_r       <= (next_state_s == DONE);
        end
    end

    assign core_rst   = core_rst_r;
    assign mem_sel    = mem_sel_r;
    assign init_wr_en = init_wr_en_r;
    assign init_addr  = walker_addr_s;
    assign init_dat   = CLR_VAL;
    assign done       = done_r;
    assign timeout    = timeout_r;
    assign cycles     = cycles_r;

endmodule

// File: doc/run_controller.md
# run_controller

Sequencer that wraps the 8-bit processor core and owns its start/finish handshake with the test harness. On a harness request it clears data memory through a borrowed write port and releases the core from reset. It then times the run and reports completion or watchdog timeout. It sits between the harness `req`/`done` pins and the core's reset, `done` and data-memory write port.

## Interface
Parameters:
- AW, 8, data-memory address width; the clear walks 2^AW words.
- DW, 8, data-memory word width.
- CLR_VAL, 0, value written to every word during the clear.
- CLR_EN, 1, 1 = clear memory before each run; 0 = skip the CLEAR state.
- TIMEOUT, 4096, maximum RUN cycles before the watchdog fires; must be at least 2.
- CW, 16, cycle-counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- req  in  1  level start request from the harness.
- core_done  in  1  core finished (program counter reached its end value).
- core_rst  out  1  active-high reset to the core; low only in RUN.
- mem_sel  out  1  1 = controller drives the dat_mem port, 0 = core drives it.
- init_wr_en  out  1  dat_mem write enable during the clear.
- init_addr  out  AW  dat_mem address during the clear.
- init_dat  out  DW  dat_mem write data; constant CLR_VAL.
- done  out  1  run complete; held until `req` falls.
- timeout  out  1  last run ended on the watchdog.
- cycles  out  CW  RUN-cycle count of the last or current run.

## Operation
- States: IDLE, CLEAR, ARM, RUN, DONE.
- **IDLE:** core_rst=1, mem_sel=0, done=0.
  - req=1 → CLEAR if CLR_EN=1, otherwise ARM.
- **CLEAR:** mem_sel=1 and init_wr_en=1.
  - init_addr starts at 0 and increments by 1 each cycle.
  - In the cycle where init_addr = 2^AW−1 → ARM. The clear takes exactly 2^AW cycles.
- **ARM:** one cycle only. core_rst=1, mem_sel=0, init_wr_en=0.
  - cycles ← 0 and timeout ← 0.
  - Unconditional transition → RUN.
- **RUN:** core_rst=0.
  - If core_done=1 → DONE with timeout=0. cycles is not incremented on that edge.
  - Else if cycles = TIMEOUT−1 → DONE with timeout ← 1 and cycles ← TIMEOUT.
  - Else cycles ← cycles+1.
  - If core_done and the watchdog coincide, core_done wins.
- **DONE:** done=1 and core_rst=1. Core state is discarded; dat_mem contents are kept. cycles and timeout are frozen.
  - req=0 → IDLE.
- **Abort:** req=0 while in CLEAR, ARM or RUN → IDLE at the next edge.
  - done stays 0; cycles and timeout keep their current values.
  - A partial clear is not resumed; the next request restarts at address 0.
- init_dat is tied to CLR_VAL. init_addr is 0 whenever the state is not CLEAR.

## Timing
- Reset is synchronous and active-low (`reset`=0 at a clock edge) and takes priority over everything else.
- Reset values:
  - state = IDLE
  - core_rst = 1
  - mem_sel = 0, init_wr_en = 0, init_addr = 0
  - done = 0, timeout = 0, cycles = 0
- Reset asserted mid-run returns to IDLE in one edge, and the core is held in reset from that point.
- All outputs are registered or decoded from the registered state only; no input-to-output combinational paths.
- Latency with CLR_EN=1 and req sampled high at edge t:
  - CLEAR occupies the cycles after edges t+1 … t+2^AW.
  - ARM follows, then RUN. core_rst falls 2^AW+2 edges after t.
- With CLR_EN=0, core_rst falls 2 edges after t.
- done rises one edge after core_done is sampled high and falls one edge after req is sampled low.
- The counter saturates by construction: it never exceeds TIMEOUT, so it cannot wrap.

## Structure
- Shared package `ctrl_pkg`:
  - `run_state_t` enum (IDLE, CLEAR, ARM, RUN, DONE)
  - default TIMEOUT and CW constants
- One natural sub-module, `addr_walker`: an AW-bit clearable up-counter with enable, producing `last` when the count is 2^AW−1.
- State register and cycle counter live in `run_controller`.

## Test plan
1. AW=4, CLR_EN=1: pulse reset, then raise req and hold it. Expect init_wr_en for exactly 16 cycles with addresses 0..15 and init_dat=0, then one ARM cycle, then core_rst=0.
2. Drive core_done on the 37th RUN cycle. Expect done=1 on the next edge, cycles=36, timeout=0. Drop req; done=0 one edge later and state is IDLE.
3. TIMEOUT=50 with core_done held at 0. Expect done=1 and timeout=1 after 50 RUN cycles, with cycles=50.
4. Assert core_done in the same cycle the watchdog would fire. Expect timeout=0 and cycles=TIMEOUT−1.
5. Drop req at clear address 7. Expect IDLE, mem_sel=0, done=0. Re-raise req; expect the clear to restart at address 0.
6. Assert reset=0 mid-RUN at cycles=20. Expect all reset values on the next edge, core_rst=1, and no done pulse.
